// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register pending-write counters that hold ID on
// RAW hazards or when a destination's pending-write count would overflow.
module register_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            issue_wb_en,
    input  logic [4:0]      issue_dst,
    input  logic [4:0]      src1,
    input  logic [4:0]      src2,
    input  logic            src2_used,
    input  logic            wb_valid,
    input  logic [4:0]      wb_dst,
    input  logic            flush,
    output logic            stall,
    output logic [NREG-1:0] busy_vec,
    output logic [15:0]     stall_cycles,
    output logic            sb_error
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] inc_hit;
    logic [NREG-1:0] ret_hit;
    logic            src_hazard;
    logic            full_hazard;
    logic            issue_fire;
    logic            retire;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    assign src_hazard  = busy_vec[src1] | (src2_used & busy_vec[src2]);
    assign full_hazard = issue_wb_en & (cnt[issue_dst] == CNT_MAX);
    assign stall       = issue_valid & (src_hazard | full_hazard);
    assign issue_fire  = issue_valid & issue_wb_en & ~stall & (issue_dst != 5'd0);
    assign retire      = wb_valid & (wb_dst != 5'd0);

    // Register 0 is left out of the one-hot decode so it can never become busy.
    always_comb begin
        inc_hit = '0;
        ret_hit = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_hit[i] = issue_fire & (issue_dst == 5'(i));
            ret_hit[i] = retire & (wb_dst == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc_hit[i] && !ret_hit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (ret_hit[i] && !inc_hit[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // A retire with nothing pending means the pipeline lost track of a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            sb_error     <= 1'b0;
        end else begin
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (retire && (cnt[wb_dst] == '0)) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_register_scoreboard;

    localparam int NREG = 32;
    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_wb_en = 1'b0;
    logic [4:0]      issue_dst = '0;
    logic [4:0]      src1 = '0;
    logic [4:0]      src2 = '0;
    logic            src2_used = 1'b0;
    logic            wb_valid = 1'b0;
    logic [4:0]      wb_dst = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic [NREG-1:0] busy_vec;
    logic [15:0]     stall_cycles;
    logic            sb_error;

    int n_cmp = 0;
    int n_err = 0;

    int mcnt [NREG];
    int mstc;
    bit merr;

    register_scoreboard #(.NREG(NREG), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dst(issue_dst),
        .src1(src1), .src2(src2), .src2_used(src2_used),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
        .stall(stall), .busy_vec(busy_vec), .stall_cycles(stall_cycles), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    function automatic bit exp_stall();
        return issue_valid && ((mcnt[src1] != 0) || (src2_used && mcnt[src2] != 0) ||
                               (issue_wb_en && mcnt[issue_dst] == MAXC));
    endfunction

    function automatic logic [NREG-1:0] exp_busy();
        logic [NREG-1:0] b;
        b = '0;
        for (int i = 0; i < NREG; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts pending writes per register from the issue/retire rules.
    always @(posedge clk or negedge rst_n) begin
        bit s, fire, ret;
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) mcnt[i] = 0;
            mstc = 0;
            merr = 0;
        end else begin
            s    = exp_stall();
            fire = issue_valid && issue_wb_en && !s && issue_dst != 0;
            ret  = wb_valid && wb_dst != 0;
            if (s && mstc < 65535) mstc = mstc + 1;
            if (ret && mcnt[wb_dst] == 0) merr = 1;
            if (flush) begin
                for (int i = 0; i < NREG; i++) mcnt[i] = 0;
            end else if (!(fire && ret && issue_dst == wb_dst)) begin
                if (fire) mcnt[issue_dst] = mcnt[issue_dst] + 1;
                if (ret && mcnt[wb_dst] > 0) mcnt[wb_dst] = mcnt[wb_dst] - 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("stall", 64'(stall), 64'(exp_stall()));
        chk("busy_vec", 64'(busy_vec), 64'(exp_busy()));
        chk("stall_cycles", 64'(stall_cycles), 64'(mstc));
        chk("sb_error", 64'(sb_error), 64'(merr));
    end

    task automatic set_in(input bit iv, input bit wen, input int dst, input int s1, input int s2,
                          input bit s2u, input bit wv, input int wd, input bit fl);
        issue_valid = iv;  issue_wb_en = wen;  issue_dst = 5'(dst);
        src1 = 5'(s1);     src2 = 5'(s2);      src2_used = s2u;
        wb_valid = wv;     wb_dst = 5'(wd);    flush = fl;
    endtask

    task automatic to_neg();
        @(negedge clk); #1;
    endtask

    task automatic to_pos();
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        to_pos();
    endtask

    initial begin
        int busy_list [$];
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        to_neg();
        chk("reset_busy", 64'(busy_vec), 64'd0);
        chk("reset_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("reset_sb_error", 64'(sb_error), 64'd0);
        to_pos();

        // RAW hazard on r5 cleared by a retire
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0);
        to_neg(); chk("raw_c0_stall", 64'(stall), 64'd0); to_pos();
        for (int k = 1; k <= 3; k++) begin
            set_in(1, 0, 0, 5, 0, 0, k == 3, 5, 0);
            to_neg(); chk("raw_stall", 64'(stall), 64'd1); to_pos();
        end
        set_in(1, 0, 0, 5, 0, 0, 0, 0, 0);
        to_neg();
        chk("raw_c4_stall", 64'(stall), 64'd0);
        chk("raw_c4_busy5", 64'(busy_vec[5]), 64'd0);
        chk("raw_stall_cycles", 64'(stall_cycles), 64'd3);
        to_pos();

        // Counter saturation on r7
        repeat (3) begin
            set_in(1, 1, 7, 0, 0, 0, 0, 0, 0);
            to_neg(); chk("fill_r7_stall", 64'(stall), 64'd0); to_pos();
        end
        set_in(1, 1, 7, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("full_r7_stall", 64'(stall), 64'd1);
        chk("model_r7_cnt", 64'(mcnt[7]), 64'd3);
        to_pos();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("model_r7_held", 64'(mcnt[7]), 64'd3);
        chk("busy_r7", 64'(busy_vec[7]), 64'd1);
        to_pos();
        repeat (3) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 7, 0);
            to_neg(); to_pos();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("drain_r7_busy", 64'(busy_vec[7]), 64'd0);
        chk("drain_sb_error", 64'(sb_error), 64'd0);
        to_pos();

        // Simultaneous issue and retire on r9
        set_in(1, 1, 9, 0, 0, 0, 0, 0, 0);
        to_neg(); to_pos();
        set_in(1, 1, 9, 0, 0, 0, 1, 9, 0);
        to_neg(); chk("same_r9_stall", 64'(stall), 64'd0); to_pos();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("same_r9_busy", 64'(busy_vec[9]), 64'd1);
        chk("model_r9_cnt", 64'(mcnt[9]), 64'd1);
        to_pos();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0);
        to_neg(); to_pos();

        // Register 0 is ignored
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
        to_neg(); chk("r0_issue_stall", 64'(stall), 64'd0); to_pos();
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 0);
        to_neg(); chk("r0_src_stall", 64'(stall), 64'd0); to_pos();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        to_neg(); to_pos();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("r0_busy", 64'(busy_vec), 64'd0);
        chk("r0_sb_error", 64'(sb_error), 64'd0);
        to_pos();

        // Spurious retire of r3 sets a sticky error
        set_in(0, 0, 0, 0, 0, 0, 1, 3, 0);
        to_neg(); chk("err_same_cycle", 64'(sb_error), 64'd0); to_pos();
        idle_cycle();
        to_neg(); chk("err_sticky", 64'(sb_error), 64'd1); to_pos();

        // Flush beats a simultaneous issue
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0);
        to_neg(); to_pos();
        set_in(1, 1, 4, 0, 0, 0, 0, 0, 0);
        to_neg(); to_pos();
        set_in(1, 1, 6, 0, 0, 0, 0, 0, 1);
        to_neg(); chk("pre_flush_busy", 64'(busy_vec), 64'h14); to_pos();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        chk("flush_busy", 64'(busy_vec), 64'd0);
        chk("flush_keeps_err", 64'(sb_error), 64'd1);
        to_pos();

        // Asynchronous reset between edges
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0);
        to_neg(); to_pos();
        set_in(1, 0, 0, 2, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("async_busy", 64'(busy_vec), 64'd0);
        chk("async_stall", 64'(stall), 64'd0);
        chk("async_stall_cycles", 64'(stall_cycles), 64'd0);
        chk("async_sb_error", 64'(sb_error), 64'd0);
        rst_n = 1'b1;
        to_neg(); to_pos();

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_wb_en = ($urandom_range(0, 9) < 8);
            issue_dst   = 5'($urandom_range(0, 15));
            src1        = 5'($urandom_range(0, 15));
            src2        = 5'($urandom_range(0, 15));
            src2_used   = $urandom_range(0, 1);
            busy_list.delete();
            for (int i = 1; i < NREG; i++) if (mcnt[i] != 0) busy_list.push_back(i);
            wb_valid = 1'b0;
            wb_dst   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 5) begin
                if ($urandom_range(0, 49) == 0) begin
                    wb_valid = 1'b1;
                end else if (busy_list.size() > 0) begin
                    wb_valid = 1'b1;
                    wb_dst   = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
                end
            end
            flush = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 599) != 0);
            to_neg();
            to_pos();
            rst_n = 1'b1;
        end

        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        to_neg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers, indexed by 5-bit register numbers.
REQ-002 Parameter CW, default 2: width of each per-register pending-write counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 issue_valid  input  1  an instruction in ID is presented for issue this cycle.
REQ-006 issue_wb_en  input  1  the presented instruction writes a register.
REQ-007 issue_dst  input  5  destination register of the presented instruction.
REQ-008 src1  input  5  first source register of the presented instruction.
REQ-009 src2  input  5  second source register of the presented instruction.
REQ-010 src2_used  input  1  src2 is a real operand; 0 for the immediate form.
REQ-011 wb_valid  input  1  a register write retires in WB this cycle.
REQ-012 wb_dst  input  5  register written by the retiring instruction.
REQ-013 flush  input  1  synchronous clear of all pending state after the pipeline is squashed and drained.
REQ-014 stall  output  1  hold IF/ID and inject a bubble into ID/EX this cycle.
REQ-015 busy_vec  output  NREG  bit i = 1 when register i has at least one pending write.
REQ-016 stall_cycles  output  16  saturating count of cycles with stall=1.
REQ-017 sb_error  output  1  sticky flag: a retire was seen for a register with no pending write.

Function
REQ-018 Each register i has a CW-bit counter cnt[i]; busy_vec[i] = (cnt[i] != 0).
REQ-019 Register 0 is never busy: cnt[0] stays 0, and issues or retires to register 0 are ignored.
REQ-020 stall is combinational, same cycle: issue_valid & (busy(src1) | (src2_used & busy(src2)) | (issue_wb_en & cnt[issue_dst] == 2^CW-1)).
REQ-021 issue_fire = issue_valid & issue_wb_en & ~stall & (issue_dst != 0); on fire, cnt[issue_dst] increments at the next edge.
REQ-022 retire = wb_valid & (wb_dst != 0); on retire, cnt[wb_dst] decrements at the next edge.
REQ-023 If issue_fire and retire target the same register in the same cycle, that counter is unchanged.
REQ-024 A retire to a counter already at 0 leaves the counter at 0 and sets sb_error at the next edge; sb_error is cleared only by reset.
REQ-025 A counter never wraps: saturation is prevented by the stall term in REQ-020, and a decrement below 0 is blocked by REQ-024.
REQ-026 A retire in cycle N clears busy in cycle N+1, so a dependent instruction issues in N+1 at the earliest; there is no same-cycle bypass.
REQ-027 flush=1 zeroes all counters at the next edge and takes priority over a simultaneous issue or retire; stall_cycles and sb_error are unaffected.
REQ-028 stall_cycles increments by 1 each cycle stall=1 and holds at 16'hFFFF.
REQ-029 stall depends only on the current inputs and the counter state; it never depends on its own previous value.

Reset
REQ-030 While rst_n=0, all counters, stall_cycles, and sb_error are 0, so busy_vec=0 and stall=0 (given issue_valid=0 or no busy sources).
REQ-031 Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
REQ-032 After reset is released, the first rising edge processes inputs normally.

Verification
REQ-033 Issue dst=5 at cycle 0, then present src1=5 at cycles 1-3 with wb_valid/wb_dst=5 at cycle 3 -> stall=1 in cycles 1-3, busy_vec[5]=0 and stall=0 in cycle 4, stall_cycles=3.
REQ-034 Issue three writes to r7 with no retires -> cnt=3; a fourth issue with dst=7 -> stall=1 and the counter stays 3.
REQ-035 Issue and retire to r9 in the same cycle with cnt[9]=1 -> cnt[9] stays 1 and busy_vec[9]=1.
REQ-036 Issue dst=0, then src1=0 -> stall=0 throughout and busy_vec=0; wb_dst=0 retire -> sb_error stays 0.
REQ-037 Retire r3 while cnt[3]=0 -> sb_error=1 from the next cycle, persisting until rst_n=0.
REQ-038 Counters on r2 and r4 plus flush=1 together with an issue to r6 -> busy_vec=0 next cycle; separately, rst_n pulsed low between edges -> all outputs 0 immediately.
